// File: rtl/hpdcache_pkg.sv
// Shared cache geometry and the set/tag/way-vector types used around the
// eviction controller.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_SETS      = 64;
    localparam int unsigned HPDCACHE_WAYS      = 4;
    localparam int unsigned HPDCACHE_TAG_WIDTH = 20;
    localparam int unsigned HPDCACHE_SET_WIDTH = $clog2(HPDCACHE_SETS);

    typedef logic [HPDCACHE_SET_WIDTH-1:0] set_t;
    typedef logic [HPDCACHE_TAG_WIDTH-1:0] tag_t;
    typedef logic [HPDCACHE_WAYS-1:0]      way_vector_t;

endpackage

// File: rtl/hpdcache_evict_ctrl_if.sv
// Bundle of the refill, directory, PLRU, write-back and response signals seen
// by the eviction controller; master is the controller, slave its surroundings.
interface hpdcache_evict_ctrl_if
    import hpdcache_pkg::*;
#(
    parameter int unsigned SETS      = HPDCACHE_SETS,
    parameter int unsigned WAYS      = HPDCACHE_WAYS,
    parameter int unsigned TAG_WIDTH = HPDCACHE_TAG_WIDTH
);
    localparam int unsigned SET_W = $clog2(SETS);

    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [SET_W-1:0]          req_set_i;
    logic [TAG_WIDTH-1:0]      req_tag_i;

    logic                      dir_rd_o;
    logic [SET_W-1:0]          dir_rd_set_o;
    logic [WAYS-1:0]           dir_valid_i;
    logic [WAYS-1:0]           dir_wb_i;
    logic [WAYS-1:0]           dir_dirty_i;
    logic [WAYS*TAG_WIDTH-1:0] dir_tag_i;

    logic [SET_W-1:0]          plru_set_o;
    logic [WAYS-1:0]           plru_dir_valid_o;
    logic [WAYS-1:0]           plru_dir_wb_o;
    logic [WAYS-1:0]           plru_dir_dirty_o;
    logic [WAYS-1:0]           plru_victim_i;
    logic                      plru_repl_o;
    logic [WAYS-1:0]           plru_repl_way_o;

    logic                      wbuf_valid_o;
    logic                      wbuf_ready_i;
    logic [SET_W-1:0]          wbuf_set_o;
    logic [TAG_WIDTH-1:0]      wbuf_tag_o;
    logic [WAYS-1:0]           wbuf_way_o;

    logic                      dir_inval_o;
    logic [WAYS-1:0]           dir_inval_way_o;

    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [SET_W-1:0]          rsp_set_o;
    logic [TAG_WIDTH-1:0]      rsp_tag_o;
    logic [WAYS-1:0]           rsp_way_o;
    logic                      rsp_evicted_o;

    logic [31:0]               evict_cnt_o;

    modport master (
        input  req_valid_i, req_set_i, req_tag_i,
        input  dir_valid_i, dir_wb_i, dir_dirty_i, dir_tag_i,
        input  plru_victim_i, wbuf_ready_i, rsp_ready_i,
        output req_ready_o, dir_rd_o, dir_rd_set_o,
        output plru_set_o, plru_dir_valid_o, plru_dir_wb_o, plru_dir_dirty_o,
        output plru_repl_o, plru_repl_way_o,
        output wbuf_valid_o, wbuf_set_o, wbuf_tag_o, wbuf_way_o,
        output dir_inval_o, dir_inval_way_o,
        output rsp_valid_o, rsp_set_o, rsp_tag_o, rsp_way_o, rsp_evicted_o,
        output evict_cnt_o
    );

    modport slave (
        output req_valid_i, req_set_i, req_tag_i,
        output dir_valid_i, dir_wb_i, dir_dirty_i, dir_tag_i,
        output plru_victim_i, wbuf_ready_i, rsp_ready_i,
        input  req_ready_o, dir_rd_o, dir_rd_set_o,
        input  plru_set_o, plru_dir_valid_o, plru_dir_wb_o, plru_dir_dirty_o,
        input  plru_repl_o, plru_repl_way_o,
        input  wbuf_valid_o, wbuf_set_o, wbuf_tag_o, wbuf_way_o,
        input  dir_inval_o, dir_inval_way_o,
        input  rsp_valid_o, rsp_set_o, rsp_tag_o, rsp_way_o, rsp_evicted_o,
        input  evict_cnt_o
    );

endinterface

// File: rtl/hpdcache_evict_tag_mux.sv
// One-hot AND-OR selector picking the victim way's tag out of the flattened
// per-way tag vector; an all-zero select yields a zero tag.
module hpdcache_evict_tag_mux #(
    parameter int unsigned WAYS      = 4,
    parameter int unsigned TAG_WIDTH = 20
) (
    input  logic [WAYS-1:0]           sel,
    input  logic [WAYS*TAG_WIDTH-1:0] tags,
    output logic [TAG_WIDTH-1:0]      tag
);

    always_comb begin
        tag = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            tag = tag | (tags[w*TAG_WIDTH +: TAG_WIDTH] & {TAG_WIDTH{sel[w]}});
        end
    end

endmodule

// File: rtl/hpdcache_evict_ctrl.sv
// Victim selection and eviction sequencer: reads the set's directory entry,
// lets the PLRU choose a victim, writes it back if dirty, invalidates it and
// hands the freed way to the refill path.
module hpdcache_evict_ctrl
    import hpdcache_pkg::*;
#(
    parameter int unsigned SETS      = HPDCACHE_SETS,
    parameter int unsigned WAYS      = HPDCACHE_WAYS,
    parameter int unsigned TAG_WIDTH = HPDCACHE_TAG_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hpdcache_evict_ctrl_if.master bus
);

    localparam int unsigned SET_W = $clog2(SETS);

    typedef enum logic [2:0] {
        IDLE,
        DIR_RD,
        SELECT,
        WBACK,
        INVAL,
        RSP
    } state_e;

    state_e               state_q, state_d;
    logic [SET_W-1:0]     set_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [TAG_WIDTH-1:0] victim_tag_q;
    logic [WAYS-1:0]      victim_q;
    logic                 need_wb_q;
    logic [31:0]          evict_cnt_q;

    logic [TAG_WIDTH-1:0] sel_tag;
    logic                 need_wb;
    logic                 was_valid;
    logic                 req_ready, dir_rd, wbuf_valid, dir_inval, rsp_valid, plru_repl;

    hpdcache_evict_tag_mux #(
        .WAYS      (WAYS),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_tag_mux (
        .sel  (bus.plru_victim_i),
        .tags (bus.dir_tag_i),
        .tag  (sel_tag)
    );

    // Only a valid, dirty line that the write-back path accepts needs flushing.
    assign need_wb   = |(bus.plru_victim_i & bus.dir_valid_i & bus.dir_wb_i & bus.dir_dirty_i);
    assign was_valid = |(bus.plru_victim_i & bus.dir_valid_i);

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        dir_rd     = 1'b0;
        wbuf_valid = 1'b0;
        dir_inval  = 1'b0;
        rsp_valid  = 1'b0;
        plru_repl  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid_i) state_d = DIR_RD;
            end
            DIR_RD: begin
                dir_rd  = 1'b1;
                state_d = SELECT;
            end
            SELECT: begin
                // No eligible way: re-read the directory until one frees up.
                if (bus.plru_victim_i == '0) state_d = DIR_RD;
                else if (need_wb)            state_d = WBACK;
                else if (was_valid)          state_d = INVAL;
                else                         state_d = RSP;
            end
            WBACK: begin
                wbuf_valid = 1'b1;
                if (bus.wbuf_ready_i) state_d = INVAL;
            end
            INVAL: begin
                dir_inval = 1'b1;
                state_d   = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready_i) begin
                    plru_repl = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            set_q        <= '0;
            tag_q        <= '0;
            victim_tag_q <= '0;
            victim_q     <= '0;
            need_wb_q    <= 1'b0;
            evict_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.req_valid_i) begin
                set_q <= bus.req_set_i;
                tag_q <= bus.req_tag_i;
            end
            if (state_q == SELECT) begin
                victim_q     <= bus.plru_victim_i;
                victim_tag_q <= sel_tag;
                need_wb_q    <= need_wb;
            end
            if (wbuf_valid && bus.wbuf_ready_i) evict_cnt_q <= evict_cnt_q + 32'd1;
        end
    end

    assign bus.req_ready_o      = req_ready;
    assign bus.dir_rd_o         = dir_rd;
    assign bus.dir_rd_set_o     = set_q;
    assign bus.plru_set_o       = (state_q == IDLE) ? '0 : set_q;
    assign bus.plru_dir_valid_o = bus.dir_valid_i;
    assign bus.plru_dir_wb_o    = bus.dir_wb_i;
    assign bus.plru_dir_dirty_o = bus.dir_dirty_i;
    assign bus.plru_repl_o      = plru_repl;
    assign bus.plru_repl_way_o  = victim_q;
    assign bus.wbuf_valid_o     = wbuf_valid;
    assign bus.wbuf_set_o       = set_q;
    assign bus.wbuf_tag_o       = victim_tag_q;
    assign bus.wbuf_way_o       = victim_q;
    assign bus.dir_inval_o      = dir_inval;
    assign bus.dir_inval_way_o  = victim_q;
    assign bus.rsp_valid_o      = rsp_valid;
    assign bus.rsp_set_o        = set_q;
    assign bus.rsp_tag_o        = tag_q;
    assign bus.rsp_way_o        = victim_q;
    assign bus.rsp_evicted_o    = need_wb_q;
    assign bus.evict_cnt_o      = evict_cnt_q;

endmodule

// File: tb/tb_hpdcache_evict_ctrl.sv
// Bench for the eviction controller: directed table plus randomized refills,
// each checked cycle by cycle against a transaction-level timeline model.
module tb_hpdcache_evict_ctrl;
    import hpdcache_pkg::*;

    typedef struct {
        set_t        set;
        tag_t        tag;
        way_vector_t valid;
        way_vector_t wb;
        way_vector_t dirty;
        way_vector_t victim;
        logic [79:0] tags;
        int          wstall;
        int          rstall;
        int          retries;
        bit          preset;
        int          exp_rsp;
        bit          exp_evicted;
    } vec_t;

    logic clk = 1'b0;
    logic rst_i;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] cnt_model;

    hpdcache_evict_ctrl_if #(.SETS(64), .WAYS(4), .TAG_WIDTH(20)) bus ();

    hpdcache_evict_ctrl #(.SETS(64), .WAYS(4), .TAG_WIDTH(20)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: event cycles relative to the accepting edge, derived
    // from directory state, PLRU choice and the handshake stalls.
    task automatic run_txn(input vec_t v, input bit directed);
        int   base, wb_start, wb_end, inval_cyc, rsp_start, rsp_end, first_rsp, vidx;
        bit   has_wb, has_inv, exp_rd, exp_wb, exp_inv, exp_rsp, exp_repl, ev_seen;
        tag_t vtag;
        has_wb  = |(v.victim & v.valid & v.wb & v.dirty);
        has_inv = |(v.victim & v.valid);
        vidx = 0;
        for (int w = 0; w < 4; w++) if (v.victim[w]) vidx = w;
        vtag      = v.tags[vidx*20 +: 20];
        base      = 2 * v.retries;
        wb_start  = has_wb ? 3 + base : -1;
        wb_end    = has_wb ? wb_start + v.wstall : -1;
        inval_cyc = has_wb ? wb_end + 1 : (has_inv ? 3 + base : -1);
        rsp_start = has_wb ? wb_end + 2 : (has_inv ? 4 + base : 3 + base);
        rsp_end   = rsp_start + v.rstall;
        first_rsp = -1;
        ev_seen   = 1'b0;
        for (int k = 0; k <= rsp_end + 1; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.req_valid_i = 1'b1;
                bus.req_set_i   = v.set;
                bus.req_tag_i   = v.tag;
                if (v.preset) begin
                    dut.evict_cnt_q = 32'hFFFF_FFFF;
                    cnt_model       = 32'hFFFF_FFFF;
                end
            end else begin
                bus.req_valid_i = 1'b0;
                bus.req_set_i   = 6'($urandom);
                bus.req_tag_i   = 20'($urandom);
            end
            if (k < 2 + base) begin
                bus.dir_valid_i   = 4'hF;
                bus.dir_wb_i      = 4'h0;
                bus.dir_dirty_i   = 4'hF;
                bus.plru_victim_i = 4'h0;
            end else begin
                bus.dir_valid_i   = v.valid;
                bus.dir_wb_i      = v.wb;
                bus.dir_dirty_i   = v.dirty;
                bus.plru_victim_i = v.victim;
            end
            bus.dir_tag_i    = v.tags;
            bus.wbuf_ready_i = has_wb && (k >= wb_start + v.wstall);
            bus.rsp_ready_i  = (k >= rsp_start + v.rstall);
            if (has_wb && k == wb_end + 1) cnt_model = cnt_model + 32'd1;
            #1;
            exp_rd   = (k >= 1) && (k <= 1 + base) && (k % 2 == 1);
            exp_wb   = has_wb && (k >= wb_start) && (k <= wb_end);
            exp_inv  = (k == inval_cyc);
            exp_rsp  = (k >= rsp_start) && (k <= rsp_end);
            exp_repl = (k == rsp_end);
            check("req_ready", 64'(bus.req_ready_o), 64'(k == 0 || k == rsp_end + 1));
            check("dir_rd", 64'(bus.dir_rd_o), 64'(exp_rd));
            if (exp_rd) check("dir_rd_set", 64'(bus.dir_rd_set_o), 64'(v.set));
            check("wbuf_valid", 64'(bus.wbuf_valid_o), 64'(exp_wb));
            if (exp_wb) begin
                check("wbuf_set", 64'(bus.wbuf_set_o), 64'(v.set));
                check("wbuf_tag", 64'(bus.wbuf_tag_o), 64'(vtag));
                check("wbuf_way", 64'(bus.wbuf_way_o), 64'(v.victim));
            end
            check("dir_inval", 64'(bus.dir_inval_o), 64'(exp_inv));
            if (exp_inv) check("dir_inval_way", 64'(bus.dir_inval_way_o), 64'(v.victim));
            check("rsp_valid", 64'(bus.rsp_valid_o), 64'(exp_rsp));
            if (exp_rsp) begin
                check("rsp_set", 64'(bus.rsp_set_o), 64'(v.set));
                check("rsp_tag", 64'(bus.rsp_tag_o), 64'(v.tag));
                check("rsp_way", 64'(bus.rsp_way_o), 64'(v.victim));
                check("rsp_evicted", 64'(bus.rsp_evicted_o), 64'(has_wb));
            end
            check("plru_repl", 64'(bus.plru_repl_o), 64'(exp_repl));
            if (exp_repl) check("plru_repl_way", 64'(bus.plru_repl_way_o), 64'(v.victim));
            check("plru_set", 64'(bus.plru_set_o), (k >= 1 && k <= rsp_end) ? 64'(v.set) : 64'd0);
            if (k == 2 + base) begin
                check("plru_dir_valid", 64'(bus.plru_dir_valid_o), 64'(v.valid));
                check("plru_dir_wb", 64'(bus.plru_dir_wb_o), 64'(v.wb));
                check("plru_dir_dirty", 64'(bus.plru_dir_dirty_o), 64'(v.dirty));
            end
            check("evict_cnt", 64'(bus.evict_cnt_o), 64'(cnt_model));
            if (bus.rsp_valid_o && first_rsp < 0) begin
                first_rsp = k;
                ev_seen   = bus.rsp_evicted_o;
            end
        end
        if (directed) begin
            check("rsp_latency", 64'(first_rsp), 64'(v.exp_rsp));
            check("table_evicted", 64'(ev_seen), 64'(v.exp_evicted));
        end
    endtask

    function automatic logic [79:0] rand_tags();
        logic [79:0] t;
        for (int w = 0; w < 4; w++) t[w*20 +: 20] = 20'($urandom);
        return t;
    endfunction

    vec_t table_v[6];
    vec_t rv;

    initial begin
        logic [79:0] t2;
        way_vector_t cand;
        int s, w;

        t2 = rand_tags();
        t2[2*20 +: 20] = 20'hABCDE;
        //             set    tag        valid  wb     dirty  victim tags        ws rs rt pre rsp ev
        table_v[0] = '{6'd5,  20'h12345, 4'h7, 4'h0, 4'h0, 4'h8, rand_tags(), 0, 0, 0, 0, 3,  0};
        table_v[1] = '{6'd9,  20'h0F0F0, 4'hF, 4'h0, 4'h0, 4'h2, rand_tags(), 0, 0, 0, 0, 4,  0};
        table_v[2] = '{6'd33, 20'h55555, 4'hF, 4'h4, 4'hF, 4'h4, t2,          3, 0, 0, 0, 8,  1};
        table_v[3] = '{6'd63, 20'h00ABC, 4'hF, 4'h0, 4'hE, 4'h1, rand_tags(), 0, 0, 3, 0, 10, 0};
        table_v[4] = '{6'd17, 20'hFEDCB, 4'h3, 4'h0, 4'h0, 4'h4, rand_tags(), 0, 4, 0, 0, 3,  0};
        table_v[5] = '{6'd2,  20'h13579, 4'hF, 4'h1, 4'h1, 4'h1, rand_tags(), 0, 0, 0, 1, 5,  1};

        rst_i = 1'b1;
        bus.req_valid_i = 1'b0; bus.req_set_i = '0; bus.req_tag_i = '0;
        bus.dir_valid_i = '0; bus.dir_wb_i = '0; bus.dir_dirty_i = '0; bus.dir_tag_i = '0;
        bus.plru_victim_i = '0; bus.wbuf_ready_i = 1'b0; bus.rsp_ready_i = 1'b0;
        cnt_model = 32'd0;
        #12;
        check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        check("rst_dir_rd", 64'(bus.dir_rd_o), 64'd0);
        check("rst_wbuf_valid", 64'(bus.wbuf_valid_o), 64'd0);
        check("rst_dir_inval", 64'(bus.dir_inval_o), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("rst_plru_repl", 64'(bus.plru_repl_o), 64'd0);
        check("rst_plru_set", 64'(bus.plru_set_o), 64'd0);
        check("rst_rsp_evicted", 64'(bus.rsp_evicted_o), 64'd0);
        check("rst_victim", 64'(bus.rsp_way_o), 64'd0);
        check("rst_evict_cnt", 64'(bus.evict_cnt_o), 64'd0);
        @(negedge clk);
        rst_i = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(table_v[i], 1'b1);

        // Reset while a write-back is pending drops it without a handshake.
        t2 = rand_tags();
        rv = '{6'd12, 20'h2468A, 4'hF, 4'h8, 4'h8, 4'h8, t2, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.req_valid_i   = (k == 0);
            bus.req_set_i     = rv.set;
            bus.req_tag_i     = rv.tag;
            bus.dir_valid_i   = rv.valid;
            bus.dir_wb_i      = rv.wb;
            bus.dir_dirty_i   = rv.dirty;
            bus.dir_tag_i     = rv.tags;
            bus.plru_victim_i = rv.victim;
            bus.wbuf_ready_i  = 1'b0;
            bus.rsp_ready_i   = 1'b1;
        end
        #1;
        check("pre_rst_wbuf_valid", 64'(bus.wbuf_valid_o), 64'd1);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("mid_rst_wbuf_valid", 64'(bus.wbuf_valid_o), 64'd0);
        check("mid_rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        check("mid_rst_plru_repl", 64'(bus.plru_repl_o), 64'd0);
        check("mid_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        cnt_model = 32'd0;
        check("mid_rst_evict_cnt", 64'(bus.evict_cnt_o), 64'(cnt_model));
        @(negedge clk);
        rst_i = 1'b0;
        bus.wbuf_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            check("post_rst_plru_repl", 64'(bus.plru_repl_o), 64'd0);
            check("post_rst_wbuf_valid", 64'(bus.wbuf_valid_o), 64'd0);
            check("post_rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        end

        for (int n = 0; n < 40; n++) begin
            rv.set    = 6'($urandom);
            rv.tag    = 20'($urandom);
            rv.valid  = 4'($urandom);
            rv.wb     = 4'($urandom);
            rv.dirty  = 4'($urandom);
            rv.tags   = rand_tags();
            rv.wstall = $urandom_range(0, 3);
            rv.rstall = $urandom_range(0, 3);
            rv.retries = ($urandom_range(0, 4) == 0) ? 1 : 0;
            rv.preset = 1'b0;
            rv.exp_rsp = 0;
            rv.exp_evicted = 1'b0;
            if (rv.valid != 4'hF) cand = ~rv.valid;
            else cand = ~(rv.dirty & ~rv.wb);
            if (cand == 4'h0) begin
                w = $urandom_range(0, 3);
                rv.wb[w] = 1'b1;
                cand[w] = 1'b1;
            end
            s = $urandom_range(0, 3);
            rv.victim = 4'h0;
            for (int j = 0; j < 4; j++) begin
                w = (s + j) % 4;
                if (cand[w] && rv.victim == 4'h0) rv.victim[w] = 1'b1;
            end
            run_txn(rv, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
